alu_exec_unit: RTL

- Execute-stage ALU that consumes the 3-bit ALUcontrol code produced by the ALU decoder, plus the two operands.
- Computes the result and a zero flag.
- Single-cycle ops (AND/OR/ADD/SUB/SLT) are registered with 1-cycle latency.
- MUL (ALUcontrol=101) runs as an iterative shift-add multiplier over WIDTH cycles, with a ready/valid handshake the control path uses to stall.

---
 rtl/alu_exec_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: registered single-cycle logic/arith ops plus an
// iterative shift-add multiplier with a ready/valid stall handshake.
module alu_exec_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUcontrol,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             out_valid,
    output logic [WIDTH-1:0] ALUresult,
    output logic             zero
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               out_valid_q;
    logic               in_ready_q;

    logic [WIDTH-1:0]   alu_d;
    logic [WIDTH-1:0]   acc_d;
    logic               slt_d;
    logic               accept;
    logic               last_iter;

    assign accept    = in_valid & in_ready_q;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    assign slt_d     = $signed(srcA) < $signed(srcB);
    assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Unused codes (011, 111) fall through to ADD.
    always_comb begin
        alu_d = srcA + srcB;
        case (ALUcontrol)
            OP_AND:  alu_d = srcA & srcB;
            OP_OR:   alu_d = srcA | srcB;
            OP_SUB:  alu_d = srcA - srcB;
            OP_SLT:  alu_d = {{(WIDTH-1){1'b0}}, slt_d};
            default: alu_d = srcA + srcB;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (ALUcontrol == OP_MUL) begin
                            mcand_q    <= srcA;
                            mplier_q   <= srcB;
                            acc_q      <= '0;
                            cnt_q      <= '0;
                            in_ready_q <= 1'b0;
                            state_q    <= MUL;
                        end else begin
                            result_q    <= alu_d;
                            zero_q      <= ~|alu_d;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    // Fixed WIDTH iterations; no early exit on zero multiplier.
                    if (last_iter) begin
                        result_q    <= acc_d;
                        zero_q      <= ~|acc_d;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign ALUresult = result_q;
    assign zero      = zero_q;

endmodule
